// File: rtl/delta_encoder.sv
// Streaming delta encoder: feeds an external two's-complement subtractor with the current
// and previous sample, then registers the difference with borrow/overflow/first flags.
module delta_encoder #(
  parameter int unsigned           WIDTH     = 8,
  parameter logic [WIDTH-1:0]      FIRST_REF = {WIDTH{1'b0}},
  parameter int unsigned           CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] sub_a,
  output logic [WIDTH-1:0] sub_b,
  input  logic [WIDTH-1:0] sub_diff,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_delta,
  output logic             out_borrow,
  output logic             out_ovf,
  output logic             out_first,
  output logic [CNT_W-1:0] sample_cnt
);

  typedef enum logic [0:0] {ST_FIRST = 1'b0, ST_RUN = 1'b1} ctl_state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  ctl_state_t       state_r;
  ctl_state_t       state_nxt_s;
  logic             first_pend_s;
  logic             ref_sel_s;
  logic             accept_s;
  logic [WIDTH-1:0] prev_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] out_delta_r;
  logic             out_borrow_r;
  logic             out_ovf_r;
  logic             out_first_r;
  logic [CNT_W-1:0] sample_cnt_r;

  // Signed overflow of a - b: operands differ in sign and the result sign differs from a.
  function automatic logic sub_ovf(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic [WIDTH-1:0] d);
    return (a[WIDTH-1] != b[WIDTH-1]) && (d[WIDTH-1] != a[WIDTH-1]);
  endfunction

  // Control state register: FIRST until a sample is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_FIRST;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; clear together with an accept still leaves FIRST, since that sample is the new reference.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_FIRST: begin
        if (accept_s) state_nxt_s = ST_RUN;
        else          state_nxt_s = ST_FIRST;
      end
      ST_RUN: begin
        if (clear && !accept_s) state_nxt_s = ST_FIRST;
        else                    state_nxt_s = ST_RUN;
      end
      default: state_nxt_s = ST_FIRST;
    endcase
  end

  // Control outputs and handshake / operand muxing.
  always_comb begin
    first_pend_s = (state_r == ST_FIRST);
    ref_sel_s    = first_pend_s || clear;
    in_ready     = !out_valid_r || out_ready;
    accept_s     = in_valid && in_ready;
    sub_a        = in_data;
    if (ref_sel_s) sub_b = FIRST_REF;
    else           sub_b = prev_r;
  end

  // Previous-sample register.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_r <= FIRST_REF;
    end else if (accept_s) begin
      prev_r <= in_data;
    end else begin
      prev_r <= prev_r;
    end
  end

  // Result register: loads on accept, drains on out_ready, holds data otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r  <= 1'b0;
      out_delta_r  <= {WIDTH{1'b0}};
      out_borrow_r <= 1'b0;
      out_ovf_r    <= 1'b0;
      out_first_r  <= 1'b0;
    end else if (accept_s) begin
      out_valid_r  <= 1'b1;
      out_delta_r  <= sub_diff;
      out_borrow_r <= (sub_a < sub_b);
      out_ovf_r    <= sub_ovf(sub_a, sub_b, sub_diff);
      out_first_r  <= ref_sel_s;
    end else if (out_ready) begin
      out_valid_r  <= 1'b0;
    end else begin
      out_valid_r  <= out_valid_r;
    end
  end

  // Saturating accepted-sample counter; clear restarts it (at 1 if a sample lands that cycle).
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_cnt_r <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      if (clear)                        sample_cnt_r <= CNT_ONE;
      else if (sample_cnt_r != CNT_MAX) sample_cnt_r <= sample_cnt_r + CNT_ONE;
      else                              sample_cnt_r <= sample_cnt_r;
    end else if (clear) begin
      sample_cnt_r <= {CNT_W{1'b0}};
    end else begin
      sample_cnt_r <= sample_cnt_r;
    end
  end

  assign out_valid  = out_valid_r;
  assign out_delta  = out_delta_r;
  assign out_borrow = out_borrow_r;
  assign out_ovf    = out_ovf_r;
  assign out_first  = out_first_r;
  assign sample_cnt = sample_cnt_r;

endmodule

// File: tb/tb_delta_encoder.sv
// Directed bench for delta_encoder with a result scoreboard; a second instance with
// CNT_W=2 shares the stimulus to exercise counter saturation.
module tb_delta_encoder;

  logic        clk = 1'b0;
  logic        rst, clear, in_valid, out_ready;
  logic [7:0]  in_data;
  logic        in_ready, out_valid, out_borrow, out_ovf, out_first;
  logic [7:0]  sub_a, sub_b, sub_diff, out_delta;
  logic [15:0] sample_cnt;
  logic        in_ready2, out_valid2, out_borrow2, out_ovf2, out_first2;
  logic [7:0]  sub_a2, sub_b2, sub_diff2, out_delta2;
  logic [1:0]  sample_cnt2;

  always #5 clk = ~clk;

  // Behavioural subtractors standing in for the external one.
  assign sub_diff  = sub_a - sub_b;
  assign sub_diff2 = sub_a2 - sub_b2;

  delta_encoder #(.WIDTH(8), .FIRST_REF(8'h00), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .sub_a(sub_a), .sub_b(sub_b), .sub_diff(sub_diff),
    .out_valid(out_valid), .out_ready(out_ready), .out_delta(out_delta),
    .out_borrow(out_borrow), .out_ovf(out_ovf), .out_first(out_first),
    .sample_cnt(sample_cnt));

  delta_encoder #(.WIDTH(8), .FIRST_REF(8'h00), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .sub_a(sub_a2), .sub_b(sub_b2), .sub_diff(sub_diff2),
    .out_valid(out_valid2), .out_ready(out_ready), .out_delta(out_delta2),
    .out_borrow(out_borrow2), .out_ovf(out_ovf2), .out_first(out_first2),
    .sample_cnt(sample_cnt2));

  typedef struct {
    logic [7:0] d;
    logic       b;
    logic       o;
    logic       f;
  } res_t;

  res_t        q[$];
  logic [7:0]  m_prev;
  logic        m_first;
  logic [15:0] m_cnt;
  logic [1:0]  m_cnt2;
  int          total  = 0;
  int          passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock: check combinational outputs and held results, update model, advance.
  task automatic cycle();
    logic       exp_rdy, acc;
    logic [7:0] a, b, d;
    res_t       r;
    #1;
    if (rst) begin
      q.delete();
      m_prev = 8'h00; m_first = 1'b1; m_cnt = 16'd0; m_cnt2 = 2'd0;
    end else begin
      exp_rdy = (q.size() == 0) || out_ready;
      acc     = in_valid && exp_rdy;
      a = in_data;
      b = (m_first || clear) ? 8'h00 : m_prev;
      d = a - b;
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      chk("sub_b", {24'd0, sub_b}, {24'd0, b});
      chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
      chk("sample_cnt", {16'd0, sample_cnt}, {16'd0, m_cnt});
      chk("sample_cnt2", {30'd0, sample_cnt2}, {30'd0, m_cnt2});
      if (q.size() != 0 && out_valid) begin
        chk("out_delta", {24'd0, out_delta}, {24'd0, q[0].d});
        chk("out_flags", {29'd0, out_borrow, out_ovf, out_first}, {29'd0, q[0].b, q[0].o, q[0].f});
        if (out_ready) void'(q.pop_front());
      end
      if (acc) begin
        r.d = d;
        r.b = (a < b);
        r.o = (a[7] != b[7]) && (d[7] != a[7]);
        r.f = m_first || clear;
        q.push_back(r);
        m_prev  = a;
        m_first = 1'b0;
        m_cnt   = clear ? 16'd1 : ((m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1);
        m_cnt2  = clear ? 2'd1 : ((m_cnt2 == 2'd3) ? m_cnt2 : m_cnt2 + 2'd1);
      end else if (clear) begin
        m_first = 1'b1; m_cnt = 16'd0; m_cnt2 = 2'd0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic feed(input logic [7:0] v);
    in_valid = 1'b1; in_data = v; cycle();
  endtask

  task automatic idle();
    in_valid = 1'b0; cycle();
  endtask

  // Direct check of the registered result against spec-given constants.
  task automatic expect_out(input string tag, input logic [7:0] d, input logic b, input logic o,
                            input logic f);
    chk({tag, "_delta"}, {24'd0, out_delta}, {24'd0, d});
    chk({tag, "_flags"}, {29'd0, out_borrow, out_ovf, out_first}, {29'd0, b, o, f});
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    expect_out("rst", 8'h00, 1'b0, 1'b0, 1'b0);
    chk("rst_cnt", {16'd0, sample_cnt}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);

    // Basic stream.
    feed(8'h10); expect_out("t1a", 8'h10, 1'b0, 1'b0, 1'b1);
    feed(8'h30); expect_out("t1b", 8'h20, 1'b0, 1'b0, 1'b0);
    feed(8'h25); expect_out("t1c", 8'hF5, 1'b1, 1'b0, 1'b0);
    chk("t1_cnt", {16'd0, sample_cnt}, 32'd3);
    idle();

    // Backpressure: result held, no sample lost.
    feed(8'h40);
    out_ready = 1'b0; in_data = 8'h50;
    cycle(); cycle(); cycle();
    expect_out("t2_hold", 8'h1B, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b1;
    cycle();
    expect_out("t2_rel", 8'h10, 1'b0, 1'b0, 1'b0);
    idle();

    // Signed overflow corners.
    feed(8'h80);
    feed(8'h7F); expect_out("t3a", 8'hFF, 1'b1, 1'b1, 1'b0);
    feed(8'h80); expect_out("t3b", 8'h01, 1'b0, 1'b1, 1'b0);
    idle();

    // Clear with and without accept.
    feed(8'h50);
    clear = 1'b1; feed(8'h40); clear = 1'b0;
    expect_out("t4", 8'h40, 1'b0, 1'b0, 1'b1);
    chk("t4_cnt", {16'd0, sample_cnt}, 32'd1);
    clear = 1'b1; idle(); clear = 1'b0;
    feed(8'h05); expect_out("t4b", 8'h05, 1'b0, 1'b0, 1'b1);
    idle();

    // Reset while a result is held.
    feed(8'h11);
    out_ready = 1'b0; idle();
    rst = 1'b1; cycle(); rst = 1'b0;
    #1;
    chk("t5_valid", {31'd0, out_valid}, 32'd0);
    expect_out("t5", 8'h00, 1'b0, 1'b0, 1'b0);
    chk("t5_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    out_ready = 1'b1;
    feed(8'h22); expect_out("t5b", 8'h22, 1'b0, 1'b0, 1'b1);
    idle();

    // Counter saturation on the narrow instance.
    clear = 1'b1; idle(); clear = 1'b0;
    for (int i = 0; i < 5; i++) feed(8'(8'h03 * i + 8'h01));
    chk("t6_sat", {30'd0, sample_cnt2}, 32'd3);
    chk("t6_wide", {16'd0, sample_cnt}, 32'd5);
    clear = 1'b1; idle(); clear = 1'b0;
    chk("t6_clr", {30'd0, sample_cnt2}, 32'd0);
    idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
